// File: rtl/bcd_round_pkg.sv
// Shared definitions for the sequential BCD rounder.
//   - MODE_*  : 2-bit rounding mode codes carried on in_mode
//   - ST_*    : FSM state encoding of bcd_round_seq
//   - bcd_inc : single-digit BCD increment returning {carry, next}
package bcd_round_pkg;

  localparam logic [1:0] MODE_TRUNC     = 2'd0;
  localparam logic [1:0] MODE_HALF_UP   = 2'd1;
  localparam logic [1:0] MODE_HALF_EVEN = 2'd2;
  localparam logic [1:0] MODE_UP        = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RIPPLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Any digit >= 9 (illegal 10..15 included) wraps to 0 with carry.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
    if (digit >= 4'd9) begin
      return {1'b1, 4'd0};
    end
    return {1'b0, digit + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_round_seq_if.sv
// Handshake bundle for bcd_round_seq.
//   master : producer of input words / consumer of results (e.g. testbench)
//   slave  : the rounder itself
interface bcd_round_seq_if #(
  parameter int unsigned NDIG = 7,
  parameter int unsigned KEEP = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*NDIG-1:0]     in_digits;
  logic [1:0]            in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*KEEP-1:0]     out_digits;
  logic                  out_ovf;
  logic                  out_rounded;
  logic                  out_err;

  modport master (
    output in_valid, in_digits, in_mode, out_ready,
    input  in_ready, out_valid, out_digits, out_ovf, out_rounded, out_err
  );

  modport slave (
    input  in_valid, in_digits, in_mode, out_ready,
    output in_ready, out_valid, out_digits, out_ovf, out_rounded, out_err
  );
endinterface

// File: rtl/bcd_round_decide.sv
// Combinational round-up decision for an NDIG-digit BCD word keeping KEEP digits.
//   in_digits : packed BCD input, digit i at [4i+3:4i]
//   in_mode   : rounding mode (MODE_*)
//   round_up  : kept part must be incremented
//   err       : some input digit is > 9
module bcd_round_decide
  import bcd_round_pkg::*;
#(
  parameter int unsigned NDIG = 7,
  parameter int unsigned KEEP = 6
) (
  input  logic [4*NDIG-1:0] in_digits,
  input  logic [1:0]        in_mode,
  output logic              round_up,
  output logic              err
);

  localparam int unsigned D = NDIG - KEEP;

  logic [3:0] guard;
  logic [3:0] lsd;
  logic       sticky;

  assign guard = in_digits[4*(D-1) +: 4];
  assign lsd   = in_digits[4*D +: 4];

  always_comb begin
    err = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (in_digits[4*i +: 4] > 4'd9) err = 1'b1;
    end
    // Everything below the guard digit; empty when only one digit is dropped.
    sticky = 1'b0;
    for (int j = 0; j < int'(D) - 1; j++) begin
      if (in_digits[4*j +: 4] != 4'd0) sticky = 1'b1;
    end
  end

  always_comb begin
    round_up = 1'b0;
    unique case (in_mode)
      MODE_TRUNC:     round_up = 1'b0;
      MODE_HALF_UP:   round_up = (guard >= 4'd5);
      MODE_HALF_EVEN: round_up = (guard > 4'd5) || ((guard == 4'd5) && (sticky || lsd[0]));
      MODE_UP:        round_up = (guard != 4'd0) || sticky;
      default:        round_up = 1'b0;
    endcase
  end

endmodule

// File: rtl/bcd_round_seq.sv
// Sequential BCD rounder: keeps the upper KEEP of NDIG BCD digits and rounds
// them by a runtime mode, rippling the increment carry one digit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of bcd_round_seq_if (in/out valid-ready handshakes,
//              in_digits/in_mode, out_digits/out_ovf/out_rounded/out_err)
module bcd_round_seq
  import bcd_round_pkg::*;
#(
  parameter int unsigned NDIG = 7,
  parameter int unsigned KEEP = 6
) (
  input  logic           clk,
  input  logic           rst,
  bcd_round_seq_if.slave bus
);

  localparam int unsigned D  = NDIG - KEEP;
  localparam int unsigned IW = (KEEP > 1) ? $clog2(KEEP) : 1;

  if (KEEP < 1 || KEEP >= NDIG) begin : g_bad_params
    $error("bcd_round_seq: KEEP must satisfy 1 <= KEEP < NDIG");
  end

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [KEEP-1:0][3:0]  dig_q, dig_d;
  logic                  ovf_q, ovf_d;
  logic                  rnd_q, rnd_d;
  logic                  err_q, err_d;
  logic                  round_up;
  logic                  err;
  logic [3:0]            cur;
  logic [4:0]            inc;

  bcd_round_decide #(
    .NDIG (NDIG),
    .KEEP (KEEP)
  ) u_decide (
    .in_digits (bus.in_digits),
    .in_mode   (bus.in_mode),
    .round_up  (round_up),
    .err       (err)
  );

  // Digit currently being incremented.
  always_comb begin
    cur = 4'd0;
    for (int k = 0; k < int'(KEEP); k++) begin
      if (idx_q == IW'(k)) cur = dig_q[k];
    end
  end

  assign inc = bcd_inc(cur);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    rnd_d   = rnd_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          for (int k = 0; k < int'(KEEP); k++) begin
            dig_d[k] = bus.in_digits[4*(int'(D)+k) +: 4];
          end
          rnd_d   = round_up;
          err_d   = err;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = round_up ? ST_RIPPLE : ST_DONE;
        end
      end
      ST_RIPPLE: begin
        for (int k = 0; k < int'(KEEP); k++) begin
          if (idx_q == IW'(k)) dig_d[k] = inc[3:0];
        end
        if (!inc[4]) begin
          state_d = ST_DONE;
        end else if (idx_q == IW'(KEEP - 1)) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      rnd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_digits  = dig_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.out_rounded = rnd_q;
  assign bus.out_err     = err_q;

endmodule

// File: tb/tb_bcd_round_seq.sv
// Self-checking bench for bcd_round_seq: two instances (KEEP=6 and KEEP=5),
// a table of vectors with a scoreboard queue, plus handshake and reset sequences.
module tb_bcd_round_seq;
  import bcd_round_pkg::*;

  typedef struct {
    int          sel;    // 0: KEEP=6 instance, 1: KEEP=5 instance
    logic [1:0]  mode;
    logic [27:0] din;
    logic [23:0] dout;
    logic        ovf;
    logic        rnd;
    logic        err;
    int          n;
    string       name;
  } vec_t;

  typedef struct {
    logic [23:0] dout;
    logic        ovf;
    logic        rnd;
    logic        err;
    int          n;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_round_seq_if #(.NDIG(7), .KEEP(6)) if6 ();
  bcd_round_seq_if #(.NDIG(7), .KEEP(5)) if5 ();

  bcd_round_seq #(.NDIG(7), .KEEP(6)) u6 (.clk(clk), .rst(rst), .bus(if6.slave));
  bcd_round_seq #(.NDIG(7), .KEEP(5)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));

  logic        drv_valid;
  logic [27:0] drv_digits;
  logic [1:0]  drv_mode;
  logic        drv_ready;
  int          sel;

  assign if6.in_valid  = drv_valid && (sel == 0);
  assign if5.in_valid  = drv_valid && (sel == 1);
  assign if6.in_digits = drv_digits;
  assign if5.in_digits = drv_digits;
  assign if6.in_mode   = drv_mode;
  assign if5.in_mode   = drv_mode;
  assign if6.out_ready = drv_ready;
  assign if5.out_ready = drv_ready;

  logic        a_in_ready, a_out_valid, a_ovf, a_rnd, a_err;
  logic [23:0] a_digits;

  always_comb begin
    if (sel == 0) begin
      a_in_ready  = if6.in_ready;
      a_out_valid = if6.out_valid;
      a_ovf       = if6.out_ovf;
      a_rnd       = if6.out_rounded;
      a_err       = if6.out_err;
      a_digits    = if6.out_digits;
    end else begin
      a_in_ready  = if5.in_ready;
      a_out_valid = if5.out_valid;
      a_ovf       = if5.out_ovf;
      a_rnd       = if5.out_rounded;
      a_err       = if5.out_err;
      a_digits    = {4'h0, if5.out_digits};
    end
  end

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Present one word and push its expectation once the accept edge has passed.
  task automatic apply(input int s, input logic [1:0] m, input logic [27:0] d, input exp_t e);
    sel        = s;
    drv_digits = d;
    drv_mode   = m;
    drv_valid  = 1'b1;
    #0;
    chk({e.name, " in_ready"}, 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Wait (bounded) for out_valid, then pop and compare the oldest expectation.
  task automatic check_result();
    int   n;
    bit   ok;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      if (a_out_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    e = sb.pop_front();
    chk({e.name, " out_valid"}, 32'(ok), 32'd1);
    chk({e.name, " digits"}, 32'(a_digits), 32'(e.dout));
    chk({e.name, " ovf"}, 32'(a_ovf), 32'(e.ovf));
    chk({e.name, " rounded"}, 32'(a_rnd), 32'(e.rnd));
    chk({e.name, " err"}, 32'(a_err), 32'(e.err));
    chk({e.name, " latency"}, 32'(n), 32'(e.n));
  endtask

  task automatic release_out(input string name);
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_ready = 1'b0;
    chk({name, " back to idle"}, 32'(a_in_ready), 32'd1);
    chk({name, " ovf cleared"}, 32'(a_ovf), 32'd0);
  endtask

  exp_t e;

  initial begin
    vecs[0]  = '{0, MODE_HALF_UP,   28'h1234567, 24'h123457, 1'b0, 1'b1, 1'b0, 1, "hu_1234567"};
    vecs[1]  = '{0, MODE_TRUNC,     28'h1234567, 24'h123456, 1'b0, 1'b0, 1'b0, 0, "tr_1234567"};
    vecs[2]  = '{0, MODE_HALF_UP,   28'h0999995, 24'h100000, 1'b0, 1'b1, 1'b0, 6, "hu_0999995"};
    vecs[3]  = '{0, MODE_HALF_UP,   28'h9999999, 24'h000000, 1'b1, 1'b1, 1'b0, 6, "hu_9999999"};
    vecs[4]  = '{0, MODE_HALF_UP,   28'h9999994, 24'h999999, 1'b0, 1'b0, 1'b0, 0, "hu_9999994"};
    vecs[5]  = '{0, MODE_UP,        28'h1234500, 24'h123450, 1'b0, 1'b0, 1'b0, 0, "up_1234500"};
    vecs[6]  = '{0, MODE_HALF_UP,   28'h1A34567, 24'h1A3457, 1'b0, 1'b1, 1'b1, 1, "hu_1A34567"};
    vecs[7]  = '{1, MODE_HALF_EVEN, 28'h1234550, 24'h012346, 1'b0, 1'b1, 1'b0, 1, "he_1234550"};
    vecs[8]  = '{1, MODE_HALF_EVEN, 28'h1234450, 24'h012344, 1'b0, 1'b0, 1'b0, 0, "he_1234450"};
    vecs[9]  = '{1, MODE_HALF_EVEN, 28'h1234451, 24'h012345, 1'b0, 1'b1, 1'b0, 1, "he_1234451"};
    vecs[10] = '{1, MODE_HALF_EVEN, 28'h1234449, 24'h012344, 1'b0, 1'b0, 1'b0, 0, "he_1234449"};
    vecs[11] = '{1, MODE_UP,        28'h1234501, 24'h012346, 1'b0, 1'b1, 1'b0, 1, "up5_1234501"};

    rst        = 1'b1;
    drv_valid  = 1'b0;
    drv_digits = '0;
    drv_mode   = '0;
    drv_ready  = 1'b0;
    sel        = 0;

    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("reset out_valid", 32'(a_out_valid), 32'd0);
      chk("reset in_ready", 32'(a_in_ready), 32'd1);
      chk("reset digits", 32'(a_digits), 32'd0);
      chk("reset flags", {29'd0, a_ovf, a_rnd, a_err}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      e = '{vecs[i].dout, vecs[i].ovf, vecs[i].rnd, vecs[i].err, vecs[i].n, vecs[i].name};
      apply(vecs[i].sel, vecs[i].mode, vecs[i].din, e);
      check_result();
      release_out(vecs[i].name);
    end

    // Back-pressure: result held while a second word waits.
    e = '{24'h123457, 1'b0, 1'b1, 1'b0, 1, "hs_first"};
    apply(0, MODE_HALF_UP, 28'h1234567, e);
    check_result();
    drv_digits = 28'h7654321;
    drv_mode   = MODE_TRUNC;
    drv_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hs hold out_valid", 32'(a_out_valid), 32'd1);
      chk("hs hold in_ready", 32'(a_in_ready), 32'd0);
      chk("hs hold digits", 32'(a_digits), 32'h123457);
    end
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_ready = 1'b0;
    chk("hs idle after ready", 32'(a_in_ready), 32'd1);
    chk("hs out_valid dropped", 32'(a_out_valid), 32'd0);
    sb.push_back('{24'h765432, 1'b0, 1'b0, 1'b0, 0, "hs_second"});
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    check_result();
    release_out("hs_second");

    // Reset in the middle of a carry ripple.
    sel        = 0;
    drv_digits = 28'h0999995;
    drv_mode   = MODE_HALF_UP;
    drv_valid  = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst pre in_ready", 32'(a_in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst mid out_valid", 32'(a_out_valid), 32'd0);
    chk("rst mid digits", 32'(a_digits), 32'd0);
    chk("rst mid flags", {29'd0, a_ovf, a_rnd, a_err}, 32'd0);
    chk("rst mid in_ready", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    e = '{24'h123457, 1'b0, 1'b1, 1'b0, 1, "post_rst"};
    apply(0, MODE_HALF_UP, 28'h1234567, e);
    check_result();
    release_out("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
